// File: rtl/ahb_arb_pkg.sv
// Shared AHB-2 encodings and helpers for the bus arbiter.
package ahb_arb_pkg;

    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned IdxW        = $clog2(MAX_MASTERS);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational winner select for the AHB arbiter.
// AHB_ARB_ROUND_ROBIN_EN defined: round-robin starting after ptr.
// Undefined: fixed priority, lowest requesting index wins, no ptr port.
module ahb_arb_picker
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0] busreq,
`ifdef AHB_ARB_ROUND_ROBIN_EN
    input  logic [IdxW-1:0]        ptr,
`endif
    output logic [IdxW-1:0]        winner
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    int unsigned best;
    int unsigned dist;

    // Nearest requester strictly after ptr; ptr itself is the last choice.
    always_comb begin
        winner = IdxW'(DEFAULT_MASTER);
        best   = NUM_MASTERS;
        dist   = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            dist = (i + NUM_MASTERS - 1 - 32'(ptr)) % NUM_MASTERS;
            if (busreq[i] && dist < best) begin
                best   = dist;
                winner = IdxW'(i);
            end
        end
    end
`else
    // Lowest requesting index wins; descending scan lets the lowest overwrite.
    always_comb begin
        winner = IdxW'(DEFAULT_MASTER);
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (busreq[i]) begin
                winner = IdxW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-2 bus arbiter: registered one-hot grant that never breaks fixed bursts
// or locked sequences, plus registered hmaster/hmastlock for the address phase.
// AHB_ARB_ROUND_ROBIN_EN selects round-robin (with pointer) over fixed priority.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] busreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    logic [4:0]             rem_q;
    logic [4:0]             rem_d;
    logic                   fixed_nonseq;
    logic                   seq_beat;
    logic                   lock_hold;
    logic                   arb_ok;
    logic [IdxW-1:0]        winner;
    logic [IdxW-1:0]        owner;
    logic [NUM_MASTERS-1:0] hgrant_d;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] ptr_q;
`endif

    ahb_arb_picker #(
        .NUM_MASTERS   (NUM_MASTERS),
        .DEFAULT_MASTER(DEFAULT_MASTER)
    ) u_picker (
        .busreq(busreq),
`ifdef AHB_ARB_ROUND_ROBIN_EN
        .ptr   (ptr_q),
`endif
        .winner(winner)
    );

    // Burst tracking and the arbitration window.
    always_comb begin
        fixed_nonseq = hready && (htrans == HTRANS_NONSEQ) && (burst_len(hburst) != 5'd1);
        seq_beat     = hready && (htrans == HTRANS_SEQ);

        rem_d = rem_q;
        if (!hready && (hresp != HRESP_OKAY)) begin
            // First cycle of a two-cycle error response: the burst is abandoned.
            rem_d = '0;
        end else if (fixed_nonseq) begin
            rem_d = burst_len(hburst) - 5'd1;
        end else if (seq_beat && (rem_q != '0)) begin
            rem_d = rem_q - 5'd1;
        end

        // hgrant is one-hot, so this reduces to hlock[owner] & busreq[owner].
        lock_hold = |(hgrant & hlock & busreq);
        arb_ok    = !lock_hold &&
                    (((rem_q == '0) && !fixed_nonseq) || ((rem_q == 5'd1) && seq_beat));

        hgrant_d = arb_ok ? (NUM_MASTERS'(1) << winner) : hgrant;
    end

    // Binary index of the current grant holder.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) begin
                owner = IdxW'(i);
            end
        end
    end

    // Grant, burst counter and address-phase ownership registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hgrant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            hmaster   <= 4'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
            rem_q     <= '0;
        end else begin
            hgrant <= hgrant_d;
            rem_q  <= rem_d;
            if (hready) begin
                hmaster   <= owner;
                hmastlock <= lock_hold;
            end
        end
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    // Pointer follows the last winner of a real request.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ptr_q <= IdxW'(DEFAULT_MASTER);
        end else if (arb_ok && (|busreq)) begin
            ptr_q <= winner;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed, table-driven bench for ahb_arbiter (4 masters, default master 0).
// Expected grant/hmaster values are listed for both selection builds.
module tb_ahb_arbiter;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SGL = 3'd0, B_INC4 = 3'd3, B_INC8 = 3'd5, B_INC16 = 3'd7;
    localparam logic [1:0] R_OK = 2'd0, R_ERR = 2'd1;

    logic       hclk;
    logic       hreset;
    logic [3:0] busreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int errors;
    int checks;

    typedef struct {
        bit         rst;
        logic [3:0] busreq;
        logic [3:0] hlock;
        logic [1:0] htrans;
        logic [2:0] hburst;
        logic       hready;
        logic [1:0] hresp;
        logic [3:0] g_rr;
        logic [3:0] m_rr;
        logic [3:0] g_fp;
        logic [3:0] m_fp;
        logic       ml;
    } vec_t;

    vec_t vecs[$];

    ahb_arbiter #(
        .NUM_MASTERS   (4),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .busreq   (busreq),
        .hlock    (hlock),
        .htrans   (htrans),
        .hburst   (hburst),
        .hready   (hready),
        .hresp    (hresp),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hmastlock(hmastlock)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string nm, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] br, input logic [3:0] hl,
                       input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                       input logic [1:0] rs, input logic [3:0] grr, input logic [3:0] mrr,
                       input logic [3:0] gfp, input logic [3:0] mfp, input logic ml);
        vec_t v;
        v.rst = r;     v.busreq = br; v.hlock = hl; v.htrans = tr; v.hburst = hb;
        v.hready = rdy; v.hresp = rs; v.g_rr = grr; v.m_rr = mrr; v.g_fp = gfp;
        v.m_fp = mfp;  v.ml = ml;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] br, input logic [3:0] hl, input logic [1:0] tr,
                         input logic [2:0] hb, input logic rdy, input logic [1:0] rs);
        busreq = br; hlock = hl; htrans = tr; hburst = hb; hready = rdy; hresp = rs;
    endtask

    // Reset across one rising edge; outputs must already be at reset values.
    task automatic do_reset(input int idx);
        @(negedge hclk);
        hreset = 1'b1;
        drive(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1, R_OK);
        #1;
        check("rst_hgrant", idx, hgrant, 4'b0001);
        check("rst_hmaster", idx, hmaster, 4'd0);
        check("rst_hmastlock", idx, {3'b000, hmastlock}, 4'd0);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic tick(input logic [3:0] br, input logic [1:0] tr, input logic [2:0] hb);
        drive(br, 4'b0000, tr, hb, 1'b1, R_OK);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        hreset = 1'b1;
        drive(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1, R_OK);

        // Idle after reset: default master holds the bus for 10 cycles.
        add(1, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0001, 4'd0, 4'b0001, 4'd0, 0);
        for (int i = 0; i < 9; i++)
            add(0, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0001, 4'd0, 4'b0001, 4'd0, 0);

        // M1 and M2 request together, then keep requesting over SINGLEs.
        add(1, 4'b0110, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0010, 4'd0, 4'b0010, 4'd0, 0);
        add(0, 4'b0110, 4'b0000, T_NSEQ, B_SGL, 1, R_OK, 4'b0100, 4'd1, 4'b0010, 4'd1, 0);
        add(0, 4'b0110, 4'b0000, T_NSEQ, B_SGL, 1, R_OK, 4'b0010, 4'd2, 4'b0010, 4'd1, 0);
        add(0, 4'b0110, 4'b0000, T_NSEQ, B_SGL, 1, R_OK, 4'b0100, 4'd1, 4'b0010, 4'd1, 0);

        // M2 INCR8 with M3 waiting; two wait states; M2 drops its request near the end.
        add(1, 4'b0100, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0100, 4'd0, 4'b0100, 4'd0, 0);
        add(0, 4'b0100, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_NSEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 0, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 0, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1000, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1000, 4'b0000, T_SEQ, B_INC8, 1, R_OK, 4'b1000, 4'd2, 4'b1000, 4'd2, 0);
        add(0, 4'b1000, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b1000, 4'd3, 4'b1000, 4'd3, 0);

        // M1 locked over three SINGLEs while M0 requests.
        add(1, 4'b0010, 4'b0010, T_IDLE, B_SGL, 1, R_OK, 4'b0010, 4'd0, 4'b0010, 4'd0, 0);
        add(0, 4'b0011, 4'b0010, T_IDLE, B_SGL, 1, R_OK, 4'b0010, 4'd1, 4'b0010, 4'd1, 1);
        add(0, 4'b0011, 4'b0010, T_NSEQ, B_SGL, 1, R_OK, 4'b0010, 4'd1, 4'b0010, 4'd1, 1);
        add(0, 4'b0011, 4'b0010, T_NSEQ, B_SGL, 1, R_OK, 4'b0010, 4'd1, 4'b0010, 4'd1, 1);
        add(0, 4'b0001, 4'b0000, T_NSEQ, B_SGL, 1, R_OK, 4'b0001, 4'd1, 4'b0001, 4'd1, 0);
        add(0, 4'b0001, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0001, 4'd0, 4'b0001, 4'd0, 0);

        // M2 INCR4 gets ERROR on beat 2; M3 takes over right after the response.
        add(1, 4'b0100, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0100, 4'd0, 4'b0100, 4'd0, 0);
        add(0, 4'b0100, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_NSEQ, B_INC4, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC4, 1, R_OK, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1100, 4'b0000, T_SEQ, B_INC4, 0, R_ERR, 4'b0100, 4'd2, 4'b0100, 4'd2, 0);
        add(0, 4'b1000, 4'b0000, T_IDLE, B_INC4, 1, R_ERR, 4'b1000, 4'd2, 4'b1000, 4'd2, 0);
        add(0, 4'b1000, 4'b0000, T_IDLE, B_SGL, 1, R_OK, 4'b1000, 4'd3, 4'b1000, 4'd3, 0);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset(k);
            drive(vecs[k].busreq, vecs[k].hlock, vecs[k].htrans, vecs[k].hburst,
                  vecs[k].hready, vecs[k].hresp);
            @(posedge hclk);
            #1;
            check("hgrant", k, hgrant, RR ? vecs[k].g_rr : vecs[k].g_fp);
            check("hmaster", k, hmaster, RR ? vecs[k].m_rr : vecs[k].m_fp);
            check("hmastlock", k, {3'b000, hmastlock}, {3'b000, vecs[k].ml});
        end

        // Asynchronous reset in the middle of an INCR16.
        do_reset(100);
        tick(4'b0100, T_IDLE, B_SGL);
        check("r16_grant", 101, hgrant, 4'b0100);
        tick(4'b0100, T_IDLE, B_SGL);
        check("r16_master", 102, hmaster, 4'd2);
        tick(4'b0100, T_NSEQ, B_INC16);
        check("r16_nseq", 103, hgrant, 4'b0100);
        tick(4'b0100, T_SEQ, B_INC16);
        check("r16_seq", 104, hgrant, 4'b0100);
        #2;
        hreset = 1'b1;
        #1;
        check("async_hgrant", 105, hgrant, 4'b0001);
        check("async_hmaster", 105, hmaster, 4'd0);
        check("async_hmastlock", 105, {3'b000, hmastlock}, 4'd0);
        @(negedge hclk);
        hreset = 1'b0;
        tick(4'b0001, T_IDLE, B_SGL);
        check("post_m0_grant", 106, hgrant, 4'b0001);
        check("post_m0_master", 106, hmaster, 4'd0);
        // Burst count must not survive reset, so M1 can be granted at once.
        tick(4'b0010, T_IDLE, B_SGL);
        check("post_m1_grant", 107, hgrant, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

AHB-2 bus arbiter for the multi-master interconnect. It samples `busreq`/`hlock` from up to 16 masters and drives a registered one-hot `hgrant`. It observes the shared address/control bus (`htrans`, `hburst`, `hready`, `hresp`) so that fixed-length bursts and locked sequences are never broken. It drives `hmaster`/`hmastlock` to the slave-side mux and to slaves.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..16.
- `DEFAULT_MASTER`, 0: master granted when nobody requests.
- `hclk` input 1: bus clock, all state on rising edge.
- `hreset` input 1: reset, asynchronous, active-high.
- `busreq` input NUM_MASTERS: per-master bus request.
- `hlock` input NUM_MASTERS: per-master lock request, qualified by `busreq`.
- `htrans` input 2: shared bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hburst` input 3: shared bus burst type (SINGLE=0, INCR=1, WRAP4..INCR16=2..7).
- `hready` input 1: shared bus ready.
- `hresp` input 2: shared bus response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- `hgrant` output NUM_MASTERS: one-hot grant, registered.
- `hmaster` output 4: index of the master owning the address phase, registered.
- `hmastlock` output 1: current address phase is locked, registered.

## Operation
- Reset values: `hgrant` = one-hot(DEFAULT_MASTER), `hmaster` = DEFAULT_MASTER, `hmastlock` = 0, `rem` = 0, `lock_hold` = 0, rr pointer = DEFAULT_MASTER.
- `rem` (5 bits) counts address beats of the current fixed burst still to be accepted.
  - Edge with `hready` & NONSEQ & fixed `hburst`: load len-1, where len is 4, 8 or 16.
  - Edge with `hready` & SEQ & `rem` > 0: decrement.
  - SINGLE and INCR never load `rem`. INCR is re-arbitrable at every beat.
- Burst abandon: when `hresp` != OKAY is sampled with `hready` = 0 (first response cycle), `rem` <= 0.
- `lock_hold` = `hlock[owner]` & `busreq[owner]`, where owner is the index currently in `hgrant`.
- `arb_ok` is combinational and true when all of the following hold:
  - `!lock_hold`;
  - either `rem` == 0 and not (`hready` & NONSEQ & fixed burst), or `rem` == 1 & `hready` & SEQ.
- Winner selection:
  - No `busreq` set: DEFAULT_MASTER.
  - Otherwise round-robin: first requester at index > rr pointer, wrapping modulo NUM_MASTERS.
- On an edge with `arb_ok`: `hgrant` <= one-hot(winner), and rr pointer <= winner if any request is set.
- When `arb_ok` is false, `hgrant` holds.
- Address-phase handover, on every edge with `hready` = 1:
  - `hmaster` <= index(`hgrant`);
  - `hmastlock` <= `hlock[index(hgrant)]` & `busreq[index(hgrant)]`.
- With `hready` = 0, `hmaster` and `hmastlock` hold.
- Simultaneous events:
  - Owner requesting with `arb_ok`: round-robin may move the grant away only if another master requests.
  - Owner alone requesting: the grant is retained.
- `hreset` mid-burst: all state returns to reset values immediately, asynchronously. No partial burst tracking survives reset.

## Timing
- Request to grant: `busreq` high before edge N makes `hgrant` valid after edge N (1 cycle), provided `arb_ok` at N.
- Grant to ownership: the first edge with `hgrant` high and `hready` = 1 updates `hmaster`. The master drives its address in the following cycle.
- Fixed burst of length L: `hgrant` is frozen from the NONSEQ edge until the edge accepting the last SEQ. The new grant is registered at that edge.
- Wait states (`hready` = 0) extend all of the above 1:1.
- No combinational path from inputs to outputs.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN` defined: round-robin selection as above.
- Undefined: fixed priority, lowest requesting index wins. The rr pointer is not implemented.
- All other behaviour is identical in both builds.

## Structure
- `ahb_arb_pkg` holds:
  - `htrans_e` and `hburst_e` enums;
  - `hresp_e` enum;
  - `burst_len(hburst)` function returning 1/4/8/16 (INCR returns 1);
  - `MAX_MASTERS` = 16.
- One sub-module, `ahb_arb_picker`: combinational winner select from `busreq`, pointer and DEFAULT_MASTER. Its `ifdef` for round-robin versus fixed priority lives there.
- The top holds the `rem` counter, `lock_hold`, grant/hmaster/hmastlock registers and the pointer.

## Test plan
- Reset idle, no requests: `hgrant` = 4'b0001, `hmaster` = 0, `hmastlock` = 0. Holds for 10 cycles.
- M1 and M2 request together with rr pointer = 0: grant M1. M1 does a SINGLE, then the grant moves to M2. Both keep requesting: grants alternate 2,1,2.
- M2 INCR8 with M3 requesting: `hgrant` stays 4'b0100 across 7 SEQ beats, including 2 inserted wait states. It changes to 4'b1000 at the edge accepting beat 8.
- M1 `hlock` + `busreq` over 3 SINGLEs with M0 requesting:
  - grant held until `hlock` drops;
  - `hmastlock` = 1 for those 3 address phases;
  - then M0 is granted.
- M2 INCR4 gets ERROR in beat 2: `rem` clears on the first ERROR cycle, and the waiting M3 is granted on the next edge.
- Assert `hreset` mid-INCR16: outputs reset asynchronously in the same cycle. After release, M0 requesting is granted 1 cycle later.
